// File: rtl/tau_pkg.sv
// Shared types and constants for the execute stage: opcodes, widths, instruction and E-stage records.
// Combinational definitions only; no latency.
// No flow control of its own.
package tau_pkg;

    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 4;
    localparam int REG_AW   = $clog2(NUM_REGS);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_INC = 4'b0010;
    localparam logic [3:0] OP_DEC = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_NOT = 4'b1010;
    localparam logic [3:0] OP_XOR = 4'b1100;
    localparam logic [3:0] OP_SL  = 4'b1110;
    localparam logic [3:0] OP_SR  = 4'b0111;

    typedef struct packed {
        logic [3:0]        opcode;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              use_imm;
        logic [DATA_W-1:0] imm;
    } instr_t;

    typedef struct packed {
        logic [3:0]        opcode;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
    } e_stage_t;

    // True when a regfile read of rs must instead take the value being written this cycle.
    function automatic logic fwd_hit(input logic wr_en, input logic [REG_AW-1:0] wr_idx,
                                     input logic [REG_AW-1:0] rs);
        return wr_en && (wr_idx == rs);
    endfunction

endpackage

// File: rtl/alu.sv
// 8-bit combinational ALU: arithmetic, logic and single-bit shifts with carry/borrow out.
// Latency: zero cycles (purely combinational).
// No flow control; caller samples result whenever it needs it.
module alu
    import tau_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        opcode,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] wide;

    // Only ADD/SUB ever set the top bit; every other op leaves it 0.
    always_comb begin
        wide = '0;
        case (opcode)
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_INC:  wide = {1'b0, a + 8'd1};
            OP_DEC:  wide = {1'b0, a - 8'd1};
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_NOT:  wide = {1'b0, ~a};
            OP_XOR:  wide = {1'b0, a ^ b};
            OP_SL:   wide = {1'b0, a << 1};
            OP_SR:   wide = {1'b0, a >> 1};
            default: wide = '0;
        endcase
    end

    assign result = wide[DATA_W-1:0];
    assign carry  = wide[DATA_W];

endmodule

// File: rtl/exec_regfile.sv
// NUM_REGS x DATA_W register file, two asynchronous read ports and one synchronous write port.
// Latency: reads combinational; a write is visible from the cycle after the write edge.
// No flow control; reset takes priority over a same-cycle write.
module exec_regfile
    import tau_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: operand read with forwarding, ALU, regfile writeback, registered result to downstream.
// Latency: accepted at edge N, result registered at edge N+1; one instruction per cycle sustained.
// Backpressure: a stalled output holds E, which drops in_ready; nothing is dropped or duplicated.
module alu_exec_unit
    import tau_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_carry,
    output logic              out_zero
);

    instr_t            instr;
    e_stage_t          e_q;
    e_stage_t          e_d;
    logic              e_valid;
    logic              e_fire;
    logic              accept;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    assign instr = {in_opcode, in_rd, in_rs1, in_rs2, in_use_imm, in_imm};

    assign e_fire   = e_valid & (~out_valid | out_ready);
    assign in_ready = ~rst & (~e_valid | e_fire);
    assign accept   = in_valid & in_ready;

    exec_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (instr.rs1),
        .rd_data_a (rf_a),
        .rd_addr_b (instr.rs2),
        .rd_data_b (rf_b),
        .wr_en     (e_fire),
        .wr_addr   (e_q.rd),
        .wr_data   (alu_result)
    );

    alu u_alu (
        .a      (e_q.op_a),
        .b      (e_q.op_b),
        .opcode (e_q.opcode),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // The instruction retiring from E this cycle has not reached the regfile yet, so take its result directly.
    always_comb begin
        e_d        = '0;
        e_d.opcode = instr.opcode;
        e_d.rd     = instr.rd;
        e_d.op_a   = fwd_hit(e_fire, e_q.rd, instr.rs1) ? alu_result : rf_a;
        if (instr.use_imm) begin
            e_d.op_b = instr.imm;
        end else begin
            e_d.op_b = fwd_hit(e_fire, e_q.rd, instr.rs2) ? alu_result : rf_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid <= 1'b0;
            e_q     <= '0;
        end else if (accept) begin
            e_valid <= 1'b1;
            e_q     <= e_d;
        end else if (e_fire) begin
            e_valid <= 1'b0;
        end
    end

    // A refill from E in the same cycle as a drain keeps out_valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            out_carry  <= 1'b0;
            out_zero   <= 1'b0;
        end else if (e_fire) begin
            out_valid  <= 1'b1;
            out_result <= alu_result;
            out_rd     <= e_q.rd;
            out_carry  <= alu_carry;
            out_zero   <= (alu_result == '0);
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table for single-issue results plus forwarding,
// backpressure and mid-flight reset sequences.
module tb_alu_exec_unit;
    import tau_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_opcode;
    logic [1:0] in_rd;
    logic [1:0] in_rs1;
    logic [1:0] in_rs2;
    logic       in_use_imm;
    logic [7:0] in_imm;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [1:0] out_rd;
    logic       out_carry;
    logic       out_zero;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_carry  (out_carry),
        .out_zero   (out_zero)
    );

    typedef struct {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic       ui;
        logic [7:0] imm;
        logic [7:0] res;
        logic       c;
        logic       z;
    } vec_t;

    vec_t vecs [22];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] obs();
        return {3'b0, out_valid, out_result, out_rd, out_carry, out_zero};
    endfunction

    function automatic logic [15:0] expo(input logic v, input logic [7:0] res, input logic [1:0] rd,
                                         input logic c, input logic z);
        return {3'b0, v, res, rd, c, z};
    endfunction

    task automatic drive(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic ui, input logic [7:0] imm);
        in_valid   = 1'b1;
        in_opcode  = op;
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_use_imm = ui;
        in_imm     = imm;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        @(negedge clk);
        check($sformatf("vec%0d_in_ready", idx), {15'b0, in_ready}, 16'd1);
        drive(v.op, v.rd, v.rs1, v.rs2, v.ui, v.imm);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("vec%0d_latency", idx), 16'(cyc), 16'd2);
        check($sformatf("vec%0d_out", idx), obs(), expo(1'b1, v.res, v.rd, v.c, v.z));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_use_imm = 1'b0; in_imm = '0;

        // Register reads after the mid-flight reset must all be zero.
        vecs[0]  = '{OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[1]  = '{OP_ADD, 2'd1, 2'd1, 2'd0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[2]  = '{OP_ADD, 2'd2, 2'd2, 2'd0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[3]  = '{OP_ADD, 2'd3, 2'd3, 2'd0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[4]  = '{OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 8'h05, 1'b0, 1'b0};
        vecs[5]  = '{OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0};
        vecs[6]  = '{OP_INC, 2'd3, 2'd0, 2'd0, 1'b1, 8'hAA, 8'h00, 1'b0, 1'b1};
        vecs[7]  = '{OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h01, 8'h00, 1'b1, 1'b1};
        vecs[8]  = '{OP_SUB, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[9]  = '{OP_ADD, 2'd3, 2'd1, 2'd0, 1'b1, 8'h81, 8'h81, 1'b0, 1'b0};
        vecs[10] = '{OP_SL,  2'd2, 2'd3, 2'd0, 1'b1, 8'hFF, 8'h02, 1'b0, 1'b0};
        vecs[11] = '{OP_SR,  2'd2, 2'd3, 2'd0, 1'b1, 8'hFF, 8'h40, 1'b0, 1'b0};
        vecs[12] = '{OP_NOT, 2'd2, 2'd3, 2'd0, 1'b1, 8'h00, 8'h7E, 1'b0, 1'b0};
        vecs[13] = '{OP_AND, 2'd2, 2'd3, 2'd0, 1'b1, 8'h0F, 8'h01, 1'b0, 1'b0};
        vecs[14] = '{OP_XOR, 2'd2, 2'd3, 2'd0, 1'b1, 8'hFF, 8'h7E, 1'b0, 1'b0};
        vecs[15] = '{OP_OR,  2'd2, 2'd3, 2'd0, 1'b1, 8'h10, 8'h91, 1'b0, 1'b0};
        vecs[16] = '{OP_DEC, 2'd2, 2'd1, 2'd0, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b0};
        vecs[17] = '{4'b0011, 2'd2, 2'd3, 2'd0, 1'b1, 8'h55, 8'h00, 1'b0, 1'b1};
        vecs[18] = '{OP_SUB, 2'd0, 2'd3, 2'd2, 1'b0, 8'h00, 8'h81, 1'b0, 1'b0};
        vecs[19] = '{OP_SUB, 2'd0, 2'd2, 2'd3, 1'b0, 8'h00, 8'h7F, 1'b1, 1'b0};
        vecs[20] = '{OP_ADD, 2'd1, 2'd3, 2'd3, 1'b0, 8'h00, 8'h02, 1'b1, 1'b0};
        vecs[21] = '{OP_SUB, 2'd1, 2'd3, 2'd3, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {15'b0, in_ready}, 16'd0);
        check("rst_out", obs(), expo(1'b0, 8'h00, 2'd0, 1'b0, 1'b0));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {15'b0, in_ready}, 16'd1);

        // Back-to-back forwarding: r1=05, r2=r1+r1, r3=r2+r1
        @(negedge clk);
        drive(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05);
        @(negedge clk);
        check("fwd_rdy1", {15'b0, in_ready}, 16'd1);
        drive(OP_ADD, 2'd2, 2'd1, 2'd1, 1'b0, 8'h00);
        @(negedge clk);
        check("fwd_out1", obs(), expo(1'b1, 8'h05, 2'd1, 1'b0, 1'b0));
        check("fwd_rdy2", {15'b0, in_ready}, 16'd1);
        drive(OP_ADD, 2'd3, 2'd2, 2'd1, 1'b0, 8'h00);
        @(negedge clk);
        in_valid = 1'b0;
        check("fwd_out2", obs(), expo(1'b1, 8'h0A, 2'd2, 1'b0, 1'b0));
        @(negedge clk);
        check("fwd_out3", obs(), expo(1'b1, 8'h0F, 2'd3, 1'b0, 1'b0));
        @(negedge clk);
        check("fwd_drain", {15'b0, out_valid}, 16'd0);

        // Backpressure: r0=11, r1=r0+1 (forwarded), r2=r1+r0 held until release
        out_ready = 1'b0;
        check("bp_rdy0", {15'b0, in_ready}, 16'd1);
        drive(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 8'h11);
        @(negedge clk);
        check("bp_rdy1", {15'b0, in_ready}, 16'd1);
        drive(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h01);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp_frozen%0d", k), obs(), expo(1'b1, 8'h11, 2'd0, 1'b0, 1'b0));
            check($sformatf("bp_stall%0d", k), {15'b0, in_ready}, 16'd0);
            drive(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b0, 8'h00);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", {15'b0, in_ready}, 16'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_out_b", obs(), expo(1'b1, 8'h12, 2'd1, 1'b0, 1'b0));
        @(negedge clk);
        check("bp_out_c", obs(), expo(1'b1, 8'h23, 2'd2, 1'b0, 1'b0));
        @(negedge clk);
        check("bp_drain", {15'b0, out_valid}, 16'd0);

        // Reset with both E and out holding: r3=r0+1 in out, r0=r0+55 pending in E
        out_ready = 1'b0;
        drive(OP_ADD, 2'd3, 2'd0, 2'd0, 1'b1, 8'h01);
        @(negedge clk);
        drive(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 8'h55);
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_out_held", obs(), expo(1'b1, 8'h12, 2'd3, 1'b0, 1'b0));
        check("mid_e_full", {15'b0, in_ready}, 16'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        check("mid_rst_out", obs(), expo(1'b0, 8'h00, 2'd0, 1'b0, 1'b0));
        @(negedge clk);
        check("mid_no_ghost", {15'b0, out_valid}, 16'd0);

        for (int i = 0; i < 22; i++) begin
            run_vec(i, vecs[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
